btb_lru: RTL and testbench



---
 rtl/btb_pkg.sv | 20 ++
 rtl/lru_age_array.sv | 58 +++++
 rtl/btb_lru.sv | 133 +++++++++++++
 tb/tb_btb_lru.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer and its LRU age tracker.
// Age 0 marks the most-recently-used entry; N_ENTRIES-1 marks the victim candidate.
package btb_pkg;

    localparam int N_ENTRIES_DEF = 4;
    localparam int W_TAG_DEF     = 8;
    localparam int W_BTA_DEF     = 32;

    localparam int AGE_MRU = 0;
    localparam int AGE_LRU = N_ENTRIES_DEF - 1;

    function automatic int age_width(input int n_entries);
        return (n_entries <= 2) ? 1 : $clog2(n_entries);
    endfunction

    function automatic int age_lru(input int n_entries);
        return n_entries - 1;
    endfunction

endpackage

// File: rtl/lru_age_array.sv
// True-LRU age vector: ages always form a permutation of 0..N_ENTRIES-1.
// Promote moves the target to age 0, demote moves it to the oldest age.
module lru_age_array
    import btb_pkg::*;
#(
    parameter int N_ENTRIES = N_ENTRIES_DEF,
    parameter int W_AGE     = age_width(N_ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_promote,
    input  logic             i_demote,
    input  logic [W_AGE-1:0] i_idx,
    output logic [W_AGE-1:0] o_lru_idx
);

    localparam logic [W_AGE-1:0] AGE_OLDEST = W_AGE'(age_lru(N_ENTRIES));
    localparam logic [W_AGE-1:0] AGE_NEWEST = W_AGE'(AGE_MRU);

    logic [N_ENTRIES-1:0][W_AGE-1:0] r_age;
    logic [W_AGE-1:0]                w_ref_age;

    assign w_ref_age = r_age[i_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_age[i] <= W_AGE'(i);
            end
        end else if (i_promote) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (W_AGE'(i) == i_idx) begin
                    r_age[i] <= AGE_NEWEST;
                end else if (r_age[i] < w_ref_age) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end else if (i_demote) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (W_AGE'(i) == i_idx) begin
                    r_age[i] <= AGE_OLDEST;
                end else if (r_age[i] > w_ref_age) begin
                    r_age[i] <= r_age[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_lru_idx = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (r_age[i] == AGE_OLDEST) begin
                o_lru_idx = W_AGE'(i);
            end
        end
    end

endmodule

// File: rtl/btb_lru.sv
// Fully associative branch target buffer with true-LRU replacement.
// Fetch looks up combinationally; execute installs, refreshes or invalidates entries.
module btb_lru
    import btb_pkg::*;
#(
    parameter  int N_ENTRIES = N_ENTRIES_DEF,
    parameter  int W_TAG     = W_TAG_DEF,
    parameter  int W_BTA     = W_BTA_DEF,
    localparam int W_AGE     = age_width(N_ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W_TAG-1:0] pc,
    output logic             hit,
    output logic [W_BTA-1:0] BTA,
    input  logic             upd_en,
    input  logic             upd_inv,
    input  logic [W_TAG-1:0] upd_pc,
    input  logic [W_BTA-1:0] upd_bta,
    output logic [W_AGE:0]   occupancy,
    output logic             evict
);

    localparam logic [W_AGE:0] OCC_ONE = (W_AGE+1)'(1);

    logic [N_ENTRIES-1:0]            r_valid;
    logic [N_ENTRIES-1:0][W_TAG-1:0] r_tag;
    logic [N_ENTRIES-1:0][W_BTA-1:0] r_bta;
    logic [W_AGE:0]                  r_occupancy;
    logic                            r_evict;

    logic [N_ENTRIES-1:0] w_hit_vec;
    logic [N_ENTRIES-1:0] w_upd_vec;
    logic [W_AGE-1:0]     w_hit_idx;
    logic [W_AGE-1:0]     w_upd_idx;
    logic [W_AGE-1:0]     w_free_idx;
    logic [W_AGE-1:0]     w_lru_idx;
    logic [W_AGE-1:0]     w_victim_idx;
    logic [W_AGE-1:0]     w_age_idx;
    logic [W_BTA-1:0]     w_bta;
    logic                 w_has_free;
    logic                 w_upd_match;
    logic                 w_install;
    logic                 w_inval;
    logic                 w_promote;
    logic                 w_demote;

    // Tags are kept unique, so OR-ing the masked targets yields the single match.
    always_comb begin
        w_hit_vec  = '0;
        w_upd_vec  = '0;
        w_hit_idx  = '0;
        w_upd_idx  = '0;
        w_bta      = '0;
        w_has_free = 1'b0;
        w_free_idx = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            w_hit_vec[i] = r_valid[i] && (r_tag[i] == pc);
            w_upd_vec[i] = r_valid[i] && (r_tag[i] == upd_pc);
            if (w_hit_vec[i]) begin
                w_hit_idx = W_AGE'(i);
                w_bta     = w_bta | r_bta[i];
            end
            if (w_upd_vec[i]) begin
                w_upd_idx = W_AGE'(i);
            end
        end
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_has_free = 1'b1;
                w_free_idx = W_AGE'(i);
            end
        end
    end

    assign hit         = |w_hit_vec;
    assign BTA         = w_bta;
    assign w_upd_match = |w_upd_vec;
    assign w_install   = upd_en && !upd_inv;
    assign w_inval     = upd_en && upd_inv && w_upd_match;

    assign w_victim_idx = w_upd_match ? w_upd_idx :
                          w_has_free  ? w_free_idx : w_lru_idx;

    // Any update suppresses the fetch-side promotion, even an invalidate that misses.
    assign w_promote = w_install || (!upd_en && hit);
    assign w_demote  = w_inval;
    assign w_age_idx = w_install ? w_victim_idx :
                       w_inval   ? w_upd_idx    : w_hit_idx;

    lru_age_array #(
        .N_ENTRIES (N_ENTRIES),
        .W_AGE     (W_AGE)
    ) u_ages (
        .clk       (clk),
        .reset     (reset),
        .i_promote (w_promote),
        .i_demote  (w_demote),
        .i_idx     (w_age_idx),
        .o_lru_idx (w_lru_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= '0;
            r_tag       <= '0;
            r_bta       <= '0;
            r_occupancy <= '0;
            r_evict     <= 1'b0;
        end else begin
            r_evict <= 1'b0;
            if (w_install) begin
                r_valid[w_victim_idx] <= 1'b1;
                r_tag[w_victim_idx]   <= upd_pc;
                r_bta[w_victim_idx]   <= upd_bta;
                if (!w_upd_match) begin
                    if (w_has_free) begin
                        r_occupancy <= r_occupancy + OCC_ONE;
                    end else begin
                        r_evict <= 1'b1;
                    end
                end
            end else if (w_inval) begin
                r_valid[w_upd_idx] <= 1'b0;
                r_occupancy        <= r_occupancy - OCC_ONE;
            end
        end
    end

    assign occupancy = r_occupancy;
    assign evict     = r_evict;

endmodule

// File: tb/tb_btb_lru.sv
// Bench for btb_lru: directed scenarios followed by random traffic, checked against
// a recency-list model (front of list = most recently used).
module tb_btb_lru;

    localparam int N  = 4;
    localparam int WT = 8;
    localparam int WB = 32;
    localparam int WA = 2;

    logic          clk;
    logic          reset;
    logic [WT-1:0] pc;
    logic          hit;
    logic [WB-1:0] BTA;
    logic          upd_en;
    logic          upd_inv;
    logic [WT-1:0] upd_pc;
    logic [WB-1:0] upd_bta;
    logic [WA:0]   occupancy;
    logic          evict;

    btb_lru #(.N_ENTRIES(N), .W_TAG(WT), .W_BTA(WB)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .hit       (hit),
        .BTA       (BTA),
        .upd_en    (upd_en),
        .upd_inv   (upd_inv),
        .upd_pc    (upd_pc),
        .upd_bta   (upd_bta),
        .occupancy (occupancy),
        .evict     (evict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit            m_valid [N];
    logic [WT-1:0] m_tag   [N];
    logic [WB-1:0] m_bta   [N];
    int            m_order [$];
    int            m_occ;
    bit            m_evict;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_find(input logic [WT-1:0] t);
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && m_tag[i] == t) return i;
        end
        return -1;
    endfunction

    function automatic int m_pos(input int k);
        for (int j = 0; j < m_order.size(); j++) begin
            if (m_order[j] == k) return j;
        end
        return -1;
    endfunction

    function automatic void m_to_front(input int k);
        m_order.delete(m_pos(k));
        m_order.push_front(k);
    endfunction

    function automatic void m_to_back(input int k);
        m_order.delete(m_pos(k));
        m_order.push_back(k);
    endfunction

    function automatic void m_reset();
        m_order.delete();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_bta[i]   = '0;
            m_order.push_back(i);
        end
        m_occ   = 0;
        m_evict = 1'b0;
    endfunction

    function automatic void m_edge(input bit rst, input logic [WT-1:0] p, input bit ue,
                                   input bit ui, input logic [WT-1:0] up, input logic [WB-1:0] ub);
        int h;
        int m;
        int v;
        if (rst) begin
            m_reset();
            return;
        end
        h       = m_find(p);
        m       = m_find(up);
        m_evict = 1'b0;
        if (ue && !ui) begin
            if (m >= 0) begin
                v = m;
            end else begin
                v = -1;
                for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) v = i;
                if (v < 0) begin
                    v       = m_order[$];
                    m_evict = 1'b1;
                end else begin
                    m_occ++;
                end
            end
            m_valid[v] = 1'b1;
            m_tag[v]   = up;
            m_bta[v]   = ub;
            m_to_front(v);
        end else if (ue && ui) begin
            if (m >= 0) begin
                m_valid[m] = 1'b0;
                m_occ--;
                m_to_back(m);
            end
        end else if (h >= 0) begin
            m_to_front(h);
        end
    endfunction

    // Called at posedge+1; checks lookup before the edge, registered state after it.
    task automatic step(input bit rst, input logic [WT-1:0] p, input bit ue, input bit ui,
                        input logic [WT-1:0] up, input logic [WB-1:0] ub);
        int h;
        reset   = rst;
        pc      = p;
        upd_en  = ue;
        upd_inv = ui;
        upd_pc  = up;
        upd_bta = ub;
        #2;
        if (!rst) begin
            h = m_find(p);
            chk("hit", 64'(hit), 64'(h >= 0));
            chk("bta", 64'(BTA), (h >= 0) ? 64'(m_bta[h]) : 64'd0);
        end
        @(posedge clk);
        m_edge(rst, p, ue, ui, up, ub);
        #1;
        chk("occupancy", 64'(occupancy), 64'(m_occ));
        chk("evict", 64'(evict), 64'(m_evict));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("age%0d", i), 64'(dut.u_ages.r_age[i]), 64'(m_pos(i)));
        end
    endtask

    task automatic look(input logic [WT-1:0] p);
        step(1'b0, p, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        reset   = 1'b1;
        pc      = '0;
        upd_en  = 1'b0;
        upd_inv = 1'b0;
        upd_pc  = '0;
        upd_bta = '0;
        m_reset();
        @(posedge clk);
        #1;

        step(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        chk("reset_occ", 64'(occupancy), 64'd0);
        look(8'h08);

        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h08, 32'h11);
        chk("fill1_occ", 64'(occupancy), 64'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h12, 32'h22);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h16, 32'h33);
        step(1'b0, 8'h12, 1'b1, 1'b0, 8'h20, 32'h44);
        chk("fill4_occ", 64'(occupancy), 64'd4);

        look(8'h08);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 32'h55);
        chk("evict_pulse", 64'(evict), 64'd1);
        look(8'h12);
        chk("evict_clear", 64'(evict), 64'd0);
        chk("victim_gone", 64'(m_find(8'h12) >= 0), 64'd0);
        look(8'h08);

        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h16, 32'h0);
        chk("inv_occ", 64'(occupancy), 64'd3);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'h40, 32'h66);
        chk("refill_evict", 64'(evict), 64'd0);
        chk("refill_occ", 64'(occupancy), 64'd4);
        look(8'h40);

        step(1'b0, 8'h20, 1'b1, 1'b1, 8'h20, 32'h0);
        chk("samecyc_occ", 64'(occupancy), 64'd3);
        look(8'h20);

        step(1'b1, 8'h50, 1'b1, 1'b0, 8'h50, 32'h77);
        look(8'h50);
        look(8'h08);
        look(8'h30);
        chk("post_reset_occ", 64'(occupancy), 64'd0);

        for (int n = 0; n < 400; n++) begin
            logic [WT-1:0] rp;
            logic [WT-1:0] ru;
            bit            rr;
            bit            re;
            bit            ri;
            rp = 8'hA0 + 8'($urandom_range(0, 7));
            ru = 8'hA0 + 8'($urandom_range(0, 7));
            rr = ($urandom_range(0, 99) == 0);
            re = ($urandom_range(0, 1) == 1);
            ri = ($urandom_range(0, 9) < 3);
            step(rr, rp, re, ri, ru, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
